uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_os.sv | 146 ++++++++++++++
 tb/tb_uart_rx_os.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Clocks per oversample tick, never below one.
  function automatic int uart_div(input int clk_freq, input int baud_rate, input int oversample);
    int q;
    q = clk_freq / (baud_rate * oversample);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick at the oversample rate.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = uart_div(clk_freq, baud_rate, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling, centre sampling and a valid/ready output.
//   state | meaning
//   IDLE  | waiting for a 1->0 edge on the synchronised line
//   START | counting to the start-bit centre to reject glitches
//   DATA  | sampling eight data bits LSB first at each bit centre
//   STOP  | sampling the stop bit, then delivering or flagging the byte
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

  logic       tick;
  logic       rx_meta, rx_s, rx_prev;
  state_t     state, state_nxt;
  logic [3:0] os_cnt, os_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, sh_nxt;
  logic       good_byte, frame_stb;

  uart_baud_tick #(
    .clk_freq  (clk_freq),
    .baud_rate (baud_rate),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_prev <= 1'b1;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      if (tick) rx_prev <= rx_s;
    end
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    good_byte = 1'b0;
    frame_stb = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s && rx_prev) begin
            state_nxt = START;
            os_nxt    = '0;
          end
        end
        START: begin
          if (os_cnt == OS_MID) begin
            os_nxt    = '0;
            bit_nxt   = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            sh_nxt  = {rx_s, shreg[7:1]};
            os_nxt  = '0;
            bit_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = STOP;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            os_nxt    = '0;
            state_nxt = IDLE;
            good_byte = rx_s;
            frame_stb = ~rx_s;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A consumer handshake in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_stb;
      overrun   <= 1'b0;
      if (good_byte) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at 1.536 MHz / 9600 baud (160 clk per bit).
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] got_q[$];
  int         fe_cyc, ov_cyc, stab_err;
  logic [7:0] last_data;
  logic       last_valid = 1'b0, last_ready = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // Observer: handshaken bytes, pulse widths and data stability while held.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cyc++;
      if (overrun) ov_cyc++;
      if (last_valid && !last_ready && rx_valid && rx_data !== last_data) stab_err++;
      last_valid = rx_valid;
      last_ready = rx_ready;
      last_data  = rx_data;
    end else begin
      last_valid = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cyc   = 0;
    ov_cyc   = 0;
    stab_err = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    clk_wait(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clk_wait(BIT_CLKS);
    end
    rx = stop_bit;
    clk_wait(BIT_CLKS);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    clk_wait(3);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    rst = 1'b1;
    clk_wait(20);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    clear_mon();
    rx_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        clk_wait(BIT_CLKS * 3);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
      end
    join
    clk_wait(20);
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
    tests++; if (got_at(0) !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h expected a5", got_at(0)); end
    tests++; if (fe_cyc != 0) begin fails++; $display("FAIL basic_ferr: got %0d expected 0", fe_cyc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_consumed: got %b expected 0", rx_valid); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_ready = 1'b1;
    rx = 1'b0;
    clk_wait(30);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_detect: got %b expected 1", busy); end
    clk_wait(10);
    rx = 1'b1;
    clk_wait(200);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL glitch_bytes: got %0d expected 0", got_q.size()); end
    tests++; if (fe_cyc != 0) begin fails++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cyc); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    clk_wait(20);
    tests++; if (fe_cyc != 1) begin fails++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cyc); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    tests++; if (ov_cyc != 0) begin fails++; $display("FAIL ferr_ovr: got %0d expected 0", ov_cyc); end
  endtask

  task automatic test_overrun();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    clk_wait(40);
    send_frame(8'h22, 1'b1);
    clk_wait(20);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL ovr_data: got %h expected 11", rx_data); end
    tests++; if (ov_cyc != 1) begin fails++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cyc); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL ovr_stable: got %0d expected 0", stab_err); end
    rx_ready = 1'b1;
    clk_wait(1);
    rx_ready = 1'b0;
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b expected 0", rx_valid); end
    tests++; if (got_at(0) !== 8'h11 || got_q.size() != 1) begin fails++; $display("FAIL ovr_consumed: got %h (n=%0d) expected 11 (n=1)", got_at(0), got_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit found;
    clear_mon();
    rx_ready = 1'b0;
    found = 1'b0;
    send_frame(8'h11, 1'b1);
    clk_wait(40);
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < BIT_CLKS * 12 && !found; i++) begin
          clk_wait(1);
          if (dut.good_byte) found = 1'b1;
        end
        if (found) begin
          rx_ready = 1'b1;
          clk_wait(1);
          rx_ready = 1'b0;
        end
      end
    join
    clk_wait(5);
    tests++; if (!found) begin fails++; $display("FAIL b2b_timeout: got no delivery expected delivery"); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL b2b_data: got %h expected 55", rx_data); end
    tests++; if (ov_cyc != 0) begin fails++; $display("FAIL b2b_ovr: got %0d expected 0", ov_cyc); end
    rx_ready = 1'b1;
    clk_wait(2);
    rx_ready = 1'b0;
    tests++; if (got_q.size() != 2 || got_at(0) !== 8'h11 || got_at(1) !== 8'h55) begin
      fails++; $display("FAIL b2b_order: got n=%0d %h %h expected n=2 11 55", got_q.size(), got_at(0), got_at(1));
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    rx_ready = 1'b1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        clk_wait(BIT_CLKS * 5 + 80);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        #2 rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_async: got %b expected 0", busy); end
        clk_wait(3);
        rst = 1'b1;
      end
    join
    clk_wait(50);
    send_frame(8'h81, 1'b1);
    clk_wait(20);
    tests++; if (got_q.size() != 1 || got_at(0) !== 8'h81) begin
      fails++; $display("FAIL rmid_byte: got n=%0d %h expected n=1 81", got_q.size(), got_at(0));
    end
    tests++; if (fe_cyc != 0 || ov_cyc != 0) begin fails++; $display("FAIL rmid_pulses: got fe=%0d ov=%0d expected 0 0", fe_cyc, ov_cyc); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] b;
    logic       stop_ok;
    clear_mon();
    exp_fe   = 0;
    rx_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_ok);
      if (stop_ok) exp_q.push_back(b);
      else exp_fe++;
      clk_wait($urandom_range(20, 300));
    end
    clk_wait(20);
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++; if (got_at(i) !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_at(i), exp_q[i]); end
    end
    tests++; if (fe_cyc != exp_fe) begin fails++; $display("FAIL rand_ferr: got %0d expected %0d", fe_cyc, exp_fe); end
    tests++; if (ov_cyc != 0) begin fails++; $display("FAIL rand_ovr: got %0d expected 0", ov_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
